// File: rtl/keypad_scan_fifo.sv
// rtl/keypad_scan_fifo.sv - matrix keypad scanner with one-key debounce and buffered event FIFO
module keypad_scan_fifo #(
  parameter  int ROWS           = 4,
  parameter  int COLS           = 4,
  parameter  int SCAN_DIV       = 4,
  parameter  int DEBOUNCE_SCANS = 3,
  parameter  int FIFO_DEPTH     = 4,
  parameter  int REPORT_RELEASE = 1,
  localparam int CODE_W         = $clog2(ROWS*COLS),
  localparam int CNT_W          = $clog2(FIFO_DEPTH) + 1
) (
  input  logic              clk,
  input  logic              rst_n,
  output logic [COLS-1:0]   col,
  input  logic [ROWS-1:0]   fil,
  output logic [CODE_W-1:0] key_code,
  output logic              key_release,
  output logic              key_valid,
  input  logic              key_ready,
  output logic [CNT_W-1:0]  fifo_count,
  output logic              overflow,
  input  logic              overflow_clr
);

  localparam int ROW_W = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam int COL_W = $clog2(COLS);
  localparam int DW    = $clog2(SCAN_DIV);
  localparam int DB_W  = $clog2(DEBOUNCE_SCANS + 1);
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam logic [DW-1:0]    DWELL_MAX = DW'(SCAN_DIV - 1);
  localparam logic [COL_W-1:0] COL_MAX   = COL_W'(COLS - 1);
  localparam logic [CNT_W-1:0] FULL_CNT  = CNT_W'(FIFO_DEPTH);

  typedef enum logic [1:0] {IDLE, CONFIRM, HELD, RELEASE} state_t;

  logic [DW-1:0]     dwell;
  logic [COL_W-1:0]  col_idx;
  logic [ROWS-1:0]   fil_m;
  logic [ROWS-1:0]   fil_s;

  state_t            state;
  logic [DB_W-1:0]   db_cnt;
  logic [ROW_W-1:0]  cand_row;
  logic [COL_W-1:0]  cand_col;
  logic [CODE_W-1:0] cand_code;

  logic              sample;
  logic              at_cand;
  logic              cand_hi;
  logic              db_done;
  logic              any_row;
  logic [ROW_W-1:0]  low_row;
  logic [CODE_W-1:0] scan_code;

  logic              push;
  logic              push_rel;
  logic [CODE_W-1:0] push_code;

  logic [CODE_W:0]   mem [FIFO_DEPTH];
  logic [PTR_W-1:0]  wptr;
  logic [PTR_W-1:0]  rptr;
  logic              full;
  logic              pop;
  logic              wr;
  logic              drop;

  // Two-flop synchroniser for the asynchronous row inputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fil_m <= '0;
      fil_s <= '0;
    end else begin
      fil_m <= fil;
      fil_s <= fil_m;
    end
  end

  // Column dwell counter and one-hot strobe rotation
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dwell   <= '0;
      col_idx <= '0;
      col     <= COLS'(1);
    end else if (dwell == DWELL_MAX) begin
      dwell   <= '0;
      col     <= {col[COLS-2:0], col[COLS-1]};
      col_idx <= (col_idx == COL_MAX) ? '0 : col_idx + 1'b1;
    end else begin
      dwell <= dwell + 1'b1;
    end
  end

  // Sample-point decode and lowest-index active row
  always_comb begin
    sample    = (dwell == DWELL_MAX);
    at_cand   = sample && (col_idx == cand_col);
    cand_hi   = fil_s[cand_row];
    db_done   = (int'(db_cnt) + 1) >= DEBOUNCE_SCANS;
    any_row   = |fil_s;
    low_row   = '0;
    for (int i = ROWS - 1; i >= 0; i--) begin
      if (fil_s[i]) low_row = ROW_W'(i);
    end
    scan_code = CODE_W'(int'(low_row) * COLS + int'(col_idx));
  end

  // Event generation: the push lands on the same edge that completes debounce
  always_comb begin
    push      = 1'b0;
    push_rel  = 1'b0;
    push_code = cand_code;
    case (state)
      IDLE: begin
        if (sample && any_row && DEBOUNCE_SCANS == 1) begin
          push      = 1'b1;
          push_code = scan_code;
        end
      end
      CONFIRM: begin
        if (at_cand && cand_hi && db_done) push = 1'b1;
      end
      HELD: begin
        if (at_cand && !cand_hi && DEBOUNCE_SCANS == 1 && REPORT_RELEASE != 0) begin
          push     = 1'b1;
          push_rel = 1'b1;
        end
      end
      RELEASE: begin
        if (at_cand && !cand_hi && db_done && REPORT_RELEASE != 0) begin
          push     = 1'b1;
          push_rel = 1'b1;
        end
      end
      default: ;
    endcase
  end

  // Single-key tracker: confirm, hold, debounce the release
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      db_cnt    <= '0;
      cand_row  <= '0;
      cand_col  <= '0;
      cand_code <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (sample && any_row) begin
            cand_row  <= low_row;
            cand_col  <= col_idx;
            cand_code <= scan_code;
            if (DEBOUNCE_SCANS == 1) begin
              db_cnt <= '0;
              state  <= HELD;
            end else begin
              db_cnt <= DB_W'(1);
              state  <= CONFIRM;
            end
          end
        end
        CONFIRM: begin
          if (at_cand) begin
            if (!cand_hi) begin
              db_cnt <= '0;
              state  <= IDLE;
            end else if (db_done) begin
              db_cnt <= '0;
              state  <= HELD;
            end else begin
              db_cnt <= db_cnt + 1'b1;
            end
          end
        end
        HELD: begin
          if (at_cand && !cand_hi) begin
            if (DEBOUNCE_SCANS == 1) begin
              db_cnt <= '0;
              state  <= IDLE;
            end else begin
              db_cnt <= DB_W'(1);
              state  <= RELEASE;
            end
          end
        end
        RELEASE: begin
          if (at_cand) begin
            if (cand_hi) begin
              db_cnt <= '0;
              state  <= HELD;
            end else if (db_done) begin
              db_cnt <= '0;
              state  <= IDLE;
            end else begin
              db_cnt <= db_cnt + 1'b1;
            end
          end
        end
        default: begin
          db_cnt <= '0;
          state  <= IDLE;
        end
      endcase
    end
  end

  assign full = (fifo_count == FULL_CNT);
  assign pop  = key_valid && key_ready;
  assign wr   = push && (!full || pop);
  assign drop = push && full && !pop;

  // Event FIFO storage and pointers; a full FIFO still accepts a push alongside a pop
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < FIFO_DEPTH; i++) mem[i] <= '0;
      wptr       <= '0;
      rptr       <= '0;
      fifo_count <= '0;
    end else begin
      if (wr) begin
        mem[wptr] <= {push_rel, push_code};
        wptr      <= wptr + 1'b1;
      end
      if (pop) rptr <= rptr + 1'b1;
      case ({wr, pop})
        2'b10:   fifo_count <= fifo_count + 1'b1;
        2'b01:   fifo_count <= fifo_count - 1'b1;
        default: ;
      endcase
    end
  end

  // Sticky drop flag; a new drop wins over a same-cycle clear
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) overflow <= 1'b0;
    else if (drop) overflow <= 1'b1;
    else if (overflow_clr) overflow <= 1'b0;
  end

  assign key_valid   = (fifo_count != '0);
  assign key_code    = mem[rptr][CODE_W-1:0];
  assign key_release = mem[rptr][CODE_W];

endmodule

// File: doc/keypad_scan_fifo.md
# keypad_scan_fifo

Parametrised matrix-keypad scanner for ROWS×COLS keypads. It drives one-hot column strobes and synchronises the row inputs. It debounces one key at a time across scan frames, generating press and optional release events. Events are buffered in a FIFO behind a valid/ready interface. The block sits between the keypad pins and the digit-entry/control logic, replacing fixed 4×4 one-shot capture with a buffered, handshaked event stream.

## Interface
- ROWS, 4: keypad rows (≥1).
- COLS, 4: keypad columns (≥2).
- SCAN_DIV, 4: clock cycles each column stays driven (≥3).
- DEBOUNCE_SCANS, 3: consecutive equal samples needed to accept a press or release (≥1).
- FIFO_DEPTH, 4: event entries (power of two, ≥2).
- REPORT_RELEASE, 1: when 1, release events are queued. When 0, releases are tracked but not queued.
- CODE_W, $clog2(ROWS*COLS): key code width (derived, not overridden).
- clk  in  1  single clock; all logic on rising edge.
- rst_n  in  1  reset, asynchronous assert, active-low.
- col  out  COLS  one-hot column strobe, active-high.
- fil  in  ROWS  raw row inputs, asynchronous, active-high when key closed.
- key_code  out  CODE_W  FIFO head code = row*COLS + col.
- key_release  out  1  FIFO head is a release (1) or press (0).
- key_valid  out  1  FIFO non-empty.
- key_ready  in  1  consumer accepts head when key_valid && key_ready.
- fifo_count  out  $clog2(FIFO_DEPTH)+1  entries stored.
- overflow  out  1  sticky: an event was dropped because the FIFO was full.
- overflow_clr  in  1  synchronous clear of overflow.

## Operation
- Reset values:
  - col = 1 (column 0).
  - Dwell counter = 0.
  - FSM = IDLE, debounce count = 0.
  - FIFO empty, so key_valid = 0 and fifo_count = 0.
  - key_code = 0, key_release = 0, overflow = 0.
  - Synchroniser flops = 0.
- Scanner:
  - The dwell counter runs 0..SCAN_DIV-1.
  - At terminal count, col rotates one position toward the MSB, with COLS-1 wrapping to column 0.
  - The sample point is the cycle where dwell = SCAN_DIV-1, using the 2-flop synchronised rows (fil_s).
  - One frame = COLS×SCAN_DIV cycles.
- Tracker FSM. All transitions occur only at a sample point; candidate code = {cand_row, cand_col}.
  - IDLE: if any fil_s bit is high, capture the lowest-index high row and the current column, and set count = 1. If DEBOUNCE_SCANS == 1, push a press event and go to HELD; otherwise go to CONFIRM.
  - CONFIRM: acts only at cand_col's sample point. If the cand_row bit is high, count++; on reaching DEBOUNCE_SCANS, push a press event, reset count, go to HELD. If the bit is low, go to IDLE with count = 0.
  - HELD: at cand_col's sample point, if the cand_row bit is low, set count = 1 and go to RELEASE (or, if DEBOUNCE_SCANS == 1, release immediately as below).
  - RELEASE: at cand_col's sample point, a low bit does count++; on reaching DEBOUNCE_SCANS, push a release event if REPORT_RELEASE is 1, then go to IDLE. A high bit sends the FSM back to HELD (bounce absorbed).
  - Other keys are ignored while not in IDLE (no rollover). A second key already held at the return to IDLE is detected on its next sample point.
- FIFO:
  - Entry = {release, code}; strict order.
  - Pop on key_valid && key_ready; key_code and key_release always show the head.
  - Push when full without a same-cycle pop: the event is dropped and overflow is set.
  - Push and pop in the same cycle while full: both occur, no drop, count unchanged.
  - Push and pop in the same cycle while empty is impossible, since a pop needs key_valid.
- overflow_clr and a new drop in the same cycle: overflow stays 1 (set wins).

## Timing
- Input to sample latency: a row change must be stable ≥2 cycles before the sample edge to be seen there.
- The push is written at the sample edge that completes debounce. key_valid, key_code and fifo_count update after that same edge, giving zero extra latency.
- Minimum press-report latency from a stable press is DEBOUNCE_SCANS-1 frames after first detection. The same holds for release.
- Pop: the head advances and fifo_count decrements after the accepting edge; the next entry is visible the following cycle.
- key_ready may be held high continuously, giving a throughput of 1 event/cycle.
- rst_n low mid-operation asynchronously forces all reset values immediately, including FIFO contents and the overflow flag. Scanning restarts at column 0, dwell 0, on the first edge after deassertion.
- Outputs are registered, with no combinational path from fil to any output. key_valid depends only on FIFO state, never on key_ready.

## Test plan
All scenarios use defaults (4×4, SCAN_DIV = 4, DEBOUNCE_SCANS = 3, depth 4).
- Reset/scan: release rst_n -> col = 0001 for 4 cycles, then 0010, 0100, 1000, 0001; key_valid = 0, fifo_count = 0, overflow = 0.
- Clean press: hold fil[2] high whenever col[1] is driven for 5 frames, then drop it -> one entry {0, code 9} after the 3rd confirming sample; after 3 low samples, entry {1, 9}; fifo_count = 2.
- Bounce: fil[0] high for col[3] in one frame, low the next -> no event; the FSM returns to IDLE and fifo_count stays 0.
- Two keys: fil[1] and fil[3] both high in column 0 -> press code 4 only; code 12 is ignored until code 4's release completes, and is then pressed on a later frame.
- Backpressure: key_ready = 0, three key press/release cycles (6 events) -> fifo_count = 4 and overflow = 1. Then key_ready = 1 -> the first 4 events drain in order; overflow_clr clears the flag.
- Reset mid-operation: rst_n low while in CONFIRM with fifo_count = 2 -> key_valid = 0, fifo_count = 0 and col = 0001 immediately; no stale event appears after release.
